// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants, state encoding and the anode decode helper for the
// seven-segment scan driver.
package seven_seg_scan_driver_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int DIGIT_W    = $clog2(NUM_DIGITS);
   localparam int SEG_W      = 7;

   localparam logic [SEG_W-1:0]      SEG_BLANK  = 7'h7F;
   localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_e;

   // Active-low one-hot anode pattern selecting a single digit.
   function automatic logic [NUM_DIGITS-1:0] anodeFor(input logic [DIGIT_W-1:0] idx);
      logic [NUM_DIGITS-1:0] an;
      an      = AN_ALL_OFF;
      an[idx] = 1'b0;
      return an;
   endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle: frame inputs from the decoder and the multiplexed
// pin outputs. The scan driver sits on the slave side.
interface seven_seg_scan_driver_if;
   import seven_seg_scan_driver_pkg::*;

   logic                        en;
   logic [NUM_DIGITS*SEG_W-1:0] digit_in;
   logic [NUM_DIGITS-1:0]       dp_in;
   logic [SEG_W-1:0]            seg_out;
   logic                        dp_out;
   logic [NUM_DIGITS-1:0]       an_out;
   logic [DIGIT_W-1:0]          cur_digit;
   logic                        frame_done;

   modport master (
      output en, digit_in, dp_in,
      input  seg_out, dp_out, an_out, cur_digit, frame_done
   );

   modport slave (
      input  en, digit_in, dp_in,
      output seg_out, dp_out, an_out, cur_digit, frame_done
   );

endinterface

// File: rtl/seven_seg_scan_driver_scan_slot_counter.sv
// Modulo-REFRESH_DIV slot counter with synchronous clear; flags the last
// blank cycle and the last cycle of each digit slot.
module scan_slot_counter #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   output logic blank_end_o,
   output logic slot_end_o
);

   localparam int CNT_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign slot_end_o  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
   assign blank_end_o = (BLANK_CYCLES > 0) && (cnt_q == CNT_W'(BLANK_LAST));

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear_i || slot_end_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Eight-digit 7-segment scan driver: snapshots a frame, then drives each digit
// for one slot with a leading blank gap. Pin outputs are registered from state.
module seven_seg_scan_driver
   import seven_seg_scan_driver_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seven_seg_scan_driver_if.slave bus
);

   localparam scan_state_e SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
   localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

   scan_state_e                 state_q, state_d;
   logic [DIGIT_W-1:0]          cur_digit_q, cur_digit_d;
   logic [NUM_DIGITS*SEG_W-1:0] snap_seg_q, snap_seg_d;
   logic [NUM_DIGITS-1:0]       snap_dp_q, snap_dp_d;
   logic                        wrap_q, wrap_d;

   logic [SEG_W-1:0]            seg_q, seg_d;
   logic                        dp_q, dp_d;
   logic [NUM_DIGITS-1:0]       an_q, an_d;
   logic [DIGIT_W-1:0]          cur_out_q, cur_out_d;
   logic                        frame_done_q, frame_done_d;

   logic cnt_clear, blank_end, slot_end;

   assign cnt_clear = !bus.en || (state_q == IDLE);

   scan_slot_counter #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_slot_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (cnt_clear),
      .blank_end_o (blank_end),
      .slot_end_o  (slot_end)
   );

   // The snapshot only moves on enable or on the digit-7 -> digit-0 wrap.
   always_comb begin
      state_d     = state_q;
      cur_digit_d = cur_digit_q;
      snap_seg_d  = snap_seg_q;
      snap_dp_d   = snap_dp_q;
      wrap_d      = 1'b0;
      if (!bus.en) begin
         state_d     = IDLE;
         cur_digit_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d     = SLOT_START;
               cur_digit_d = '0;
               snap_seg_d  = bus.digit_in;
               snap_dp_d   = bus.dp_in;
            end
            BLANK: begin
               if (blank_end) begin
                  state_d = DRIVE;
               end
            end
            DRIVE: begin
               if (slot_end) begin
                  state_d     = SLOT_START;
                  cur_digit_d = cur_digit_q + DIGIT_W'(1);
                  if (cur_digit_q == LAST_DIGIT) begin
                     wrap_d     = 1'b1;
                     snap_seg_d = bus.digit_in;
                     snap_dp_d  = bus.dp_in;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs follow the state one cycle later; dropping en blanks them at once.
   always_comb begin
      seg_d        = SEG_BLANK;
      dp_d         = 1'b1;
      an_d         = AN_ALL_OFF;
      cur_out_d    = '0;
      frame_done_d = 1'b0;
      if (bus.en) begin
         cur_out_d    = cur_digit_q;
         frame_done_d = wrap_q;
         if (state_q == DRIVE) begin
            an_d  = anodeFor(cur_digit_q);
            seg_d = snap_seg_q[int'(cur_digit_q)*SEG_W +: SEG_W];
            dp_d  = snap_dp_q[cur_digit_q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cur_digit_q  <= '0;
         snap_seg_q   <= {NUM_DIGITS{SEG_BLANK}};
         snap_dp_q    <= '1;
         wrap_q       <= 1'b0;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         an_q         <= AN_ALL_OFF;
         cur_out_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_digit_q  <= cur_digit_d;
         snap_seg_q   <= snap_seg_d;
         snap_dp_q    <= snap_dp_d;
         wrap_q       <= wrap_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         cur_out_q    <= cur_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.dp_out     = dp_q;
   assign bus.an_out     = an_q;
   assign bus.cur_digit  = cur_out_q;
   assign bus.frame_done = frame_done_q;

endmodule
